// File: rtl/hex_display_ctrl.sv
// Seven-segment decimal display controller: serial double-dabble conversion of a signed magnitude.
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module hex_display_ctrl #(
    parameter int DIGITS = 6,
    parameter int VAL_W  = 20
) (
    input  logic                  Clk,
    input  logic                  Reset_h,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    input  logic                  is_neg,
    output logic [DIGITS*8-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BCD_D = (VAL_W * 3) / 10 + 1;
    localparam int BCD_W = BCD_D * 4;
    localparam int CNT_W = $clog2(VAL_W);

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } state_t;

    state_t                        state;
    logic [VAL_W-1:0]              shift;
    logic [BCD_W-1:0]              bcd;
    logic [CNT_W-1:0]              bit_cnt;
    logic                          neg;

    logic [(BCD_D+DIGITS)*4-1:0]   bcd_ext;
    logic [DIGITS*8-1:0]           image;
    logic                          ovf;
    logic [3:0]                    nib;
    int                            mag_cap;
    int                            msd;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: +3 on nibbles >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                     input logic in_bit);
        logic [BCD_W-1:0] adj;
        for (int i = 0; i < BCD_D; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = b[4*i +: 4];
            end
        end
        return {adj[BCD_W-2:0], in_bit};
    endfunction

    // Build the display image and overflow flag from the finished BCD result.
    always_comb begin
        bcd_ext = {{(DIGITS*4){1'b0}}, bcd};
        mag_cap = neg ? DIGITS - 1 : DIGITS;
        ovf     = 1'b0;
        msd     = 0;
        image   = {(DIGITS*8){1'b1}};
        nib     = 4'd0;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd = i;
                if (i >= mag_cap) begin
                    ovf = 1'b1;
                end else begin
                    ovf = ovf;
                end
            end else begin
                msd = msd;
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            nib = bcd_ext[4*d +: 4];
            if (ovf) begin
                image[8*d +: 8] = SEG_MINUS;
            end else if (d < mag_cap) begin
`ifdef HEX_LZB_EN
                // Digit 0 is never above msd, so a zero result still shows "0".
                if (d > msd) begin
                    image[8*d +: 8] = SEG_BLANK;
                end else begin
                    image[8*d +: 8] = seg_enc(nib);
                end
`else
                image[8*d +: 8] = seg_enc(nib);
`endif
            end else if (neg) begin
                image[8*d +: 8] = SEG_MINUS;
            end else begin
                image[8*d +: 8] = SEG_BLANK;
            end
        end
    end

    // Control FSM with conversion datapath and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state    <= IDLE;
            shift    <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            neg      <= 1'b0;
            seg      <= {(DIGITS*8){1'b1}};
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift   <= value;
                        neg     <= is_neg;
                        bcd     <= '0;
                        bit_cnt <= CNT_W'(VAL_W - 1);
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                CONVERT: begin
                    bcd   <= dabble_step(bcd, shift[VAL_W-1]);
                    shift <= {shift[VAL_W-2:0], 1'b0};
                    if (bit_cnt == {CNT_W{1'b0}}) begin
                        state <= LATCH;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                LATCH: begin
                    seg      <= image;
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (DIGITS=6, VAL_W=20).
module tb_hex_display_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_h;
    logic        load;
    logic [19:0] value;
    logic        is_neg;
    logic [47:0] seg;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busy_cnt;
    int done_cnt;
    int done_k [2];
    logic [47:0] done_seg [2];

    hex_display_ctrl #(.DIGITS(6), .VAL_W(20)) dut (
        .Clk      (Clk),
        .Reset_h  (Reset_h),
        .load     (load),
        .value    (value),
        .is_neg   (is_neg),
        .seg      (seg),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse load, scramble inputs after capture, and wait (bounded) for done.
    task automatic run_conv(input logic [19:0] v, input logic n,
                            output int latency, output int bcount);
        @(negedge Clk);
        load = 1'b1; value = v; is_neg = n;
        @(negedge Clk);
        load = 1'b0; value = ~v; is_neg = ~n;
        latency = -1;
        bcount  = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge Clk);
            if (busy) bcount++;
            if (done) begin
                latency = k;
                break;
            end
        end
    endtask

    initial begin
        Reset_h = 1'b1; load = 1'b0; value = 20'd0; is_neg = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_h = 1'b0;
        check("reset_seg", seg, 48'hFFFFFFFFFFFF);
        check("reset_busy", {47'd0, busy}, 48'd0);
        check("reset_done", {47'd0, done}, 48'd0);
        check("reset_ovf", {47'd0, overflow}, 48'd0);

        run_conv(20'd123456, 1'b0, lat, busy_cnt);
        check("latency_123456", 48'(lat), 48'd21);
        check("busy_cycles", 48'(busy_cnt), 48'd21);
        check("seg_123456", seg, 48'hF9A4B0999282);
        check("ovf_123456", {47'd0, overflow}, 48'd0);
        @(negedge Clk);
        check("done_one_cycle", {47'd0, done}, 48'd0);
        check("seg_hold", seg, 48'hF9A4B0999282);

        run_conv(20'd999, 1'b1, lat, busy_cnt);
`ifdef HEX_LZB_EN
        check("seg_neg999", seg, 48'hBFFFFF909090);
`else
        check("seg_neg999", seg, 48'hBFC0C0909090);
`endif
        check("ovf_neg999", {47'd0, overflow}, 48'd0);

        run_conv(20'd0, 1'b1, lat, busy_cnt);
`ifdef HEX_LZB_EN
        check("seg_negzero", seg, 48'hBFFFFFFFFFC0);
`else
        check("seg_negzero", seg, 48'hBFC0C0C0C0C0);
`endif

        run_conv(20'd1000000, 1'b0, lat, busy_cnt);
        check("ovf_1000000", {47'd0, overflow}, 48'd1);
        check("seg_1000000", seg, 48'hBFBFBFBFBFBF);

        run_conv(20'd100000, 1'b1, lat, busy_cnt);
        check("ovf_neg100000", {47'd0, overflow}, 48'd1);
        check("seg_neg100000", seg, 48'hBFBFBFBFBFBF);

        run_conv(20'd99999, 1'b1, lat, busy_cnt);
        check("ovf_neg99999", {47'd0, overflow}, 48'd0);
        check("seg_neg99999", seg, 48'hBF9090909090);

        run_conv(20'd999999, 1'b0, lat, busy_cnt);
        check("ovf_999999", {47'd0, overflow}, 48'd0);
        check("seg_999999", seg, 48'h909090909090);

        run_conv(20'd1048575, 1'b0, lat, busy_cnt);
        check("ovf_max", {47'd0, overflow}, 48'd1);

        // load held high with value changing each cycle: captures at edges 0 and 22
        @(negedge Clk);
        done_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            value = 20'(1000 + k); is_neg = 1'b0; load = 1'b1;
            @(posedge Clk);
            #1;
            if (done) begin
                if (done_cnt < 2) begin
                    done_k[done_cnt]   = k;
                    done_seg[done_cnt] = seg;
                end
                done_cnt++;
            end
        end
        load = 1'b0;
        check("held_done_count", 48'(done_cnt), 48'd2);
        check("held_done0_edge", 48'(done_k[0]), 48'd21);
        check("held_done1_edge", 48'(done_k[1]), 48'd43);
`ifdef HEX_LZB_EN
        check("held_seg0", done_seg[0], 48'hFFFFF9C0C0C0);
        check("held_seg1", done_seg[1], 48'hFFFFF9C0A4A4);
`else
        check("held_seg0", done_seg[0], 48'hC0C0F9C0C0C0);
        check("held_seg1", done_seg[1], 48'hC0C0F9C0A4A4);
`endif
        repeat (30) @(negedge Clk);

        // reset asserted at edge 10 of a conversion
        @(negedge Clk);
        load = 1'b1; value = 20'd777; is_neg = 1'b0;
        @(negedge Clk);
        load = 1'b0;
        repeat (9) @(negedge Clk);
        Reset_h = 1'b1;
        @(negedge Clk);
        Reset_h = 1'b0;
        check("midreset_seg", seg, 48'hFFFFFFFFFFFF);
        check("midreset_busy", {47'd0, busy}, 48'd0);
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (done) done_cnt++;
        end
        check("midreset_no_done", 48'(done_cnt), 48'd0);

        run_conv(20'd4660, 1'b0, lat, busy_cnt);
        check("post_reset_latency", 48'(lat), 48'd21);
`ifdef HEX_LZB_EN
        check("post_reset_seg", seg, 48'hFFFF998282C0);
`else
        check("post_reset_seg", seg, 48'hC0C0998282C0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
